// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32IM instruction encoder: loader side is master,
// encoder side is slave. Statistics counters ride along with the response signals.
interface instr_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [1:0]       out_err;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_err, cnt_ok, cnt_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_err, cnt_ok, cnt_err
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs register fields and a signed immediate into an RV32IM word. Two-stage valid/ready
// pipeline: S1 registers the request and its error code, S2 holds the packed word.
module instr_encoder #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);

  localparam int STAGES = 2;
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [1:0]  err;
  } req_t;

  // Priority: illegal fmt, then range, then alignment.
  function automatic logic [1:0] imm_err(input logic [2:0] fmt, input logic [31:0] imm);
    logic signed [31:0] s;
    s = imm;
    imm_err = 2'd0;
    case (fmt)
      F_R:      imm_err = 2'd0;
      F_I, F_S: if (s < -32'sd2048 || s > 32'sd2047) imm_err = 2'd1;
      F_B:      if (s < -32'sd4096 || s > 32'sd4094) imm_err = 2'd1;
                else if (imm[0]) imm_err = 2'd2;
      F_U:      if (imm[11:0] != 12'd0) imm_err = 2'd2;
      F_J:      if (s < -32'sd1048576 || s > 32'sd1048574) imm_err = 2'd1;
                else if (imm[0]) imm_err = 2'd2;
      default:  imm_err = 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] pack(input req_t r);
    case (r.fmt)
      F_R:     pack = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
      F_I:     pack = {r.imm[11:0], r.rs1, r.f3, r.rd, r.op};
      F_S:     pack = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], r.op};
      F_B:     pack = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], r.op};
      F_U:     pack = {r.imm[31:12], r.rd, r.op};
      F_J:     pack = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.op};
      default: pack = NOP_WORD;
    endcase
    if (r.err != 2'd0) pack = NOP_WORD;
  endfunction

  logic [STAGES:1] vld_pipe;
  req_t            s1;
  logic [31:0]     s2_instr;
  logic [1:0]      s2_err;
  logic [CNT_W-1:0] ok_q, err_q;
  logic            s2_adv, accept, emit;

  assign s2_adv       = vld_pipe[1] & (~vld_pipe[2] | bus.out_ready);
  assign bus.in_ready = ~vld_pipe[1] | s2_adv;
  assign accept       = bus.in_valid & bus.in_ready;
  assign emit         = vld_pipe[2] & bus.out_ready;

  assign bus.out_valid = vld_pipe[2];
  assign bus.out_instr = s2_instr;
  assign bus.out_err   = s2_err;
  assign bus.cnt_ok    = ok_q;
  assign bus.cnt_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2_instr <= '0;
      s2_err   <= '0;
      ok_q     <= '0;
      err_q    <= '0;
    end else begin
      if (accept) begin
        s1 <= '{fmt: bus.in_fmt, op: bus.in_opcode, rd: bus.in_rd, rs1: bus.in_rs1,
                rs2: bus.in_rs2, f3: bus.in_funct3, f7: bus.in_funct7, imm: bus.in_imm,
                err: imm_err(bus.in_fmt, bus.in_imm)};
        vld_pipe[1] <= 1'b1;
      end else if (s2_adv) begin
        vld_pipe[1] <= 1'b0;
      end

      // S2 only reloads on advance, so a stalled output stays stable.
      if (s2_adv) begin
        vld_pipe[2] <= 1'b1;
        s2_instr    <= pack(s1);
        s2_err      <= s1.err;
      end else if (emit) begin
        vld_pipe[2] <= 1'b0;
      end

      if (emit) begin
        if (s2_err == 2'd0) begin
          if (ok_q != '1) ok_q <= ok_q + 1'b1;
        end else begin
          if (err_q != '1) err_q <= err_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: scoreboard against a format-rule model plus an
// immediate-decoder round trip on every legal item.
module tb_instr_encoder;
  localparam int          CNT_W = 8;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  err;
    int          t;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if #(.CNT_W(CNT_W)) bus ();
  instr_encoder #(.CNT_W(CNT_W), .NOP_WORD(NOP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   n_tests = 0, n_fail = 0, cyc = 0;
  int   gb = 0, ck = 0, m_ok = 0, m_err = 0;
  res_t exp_q[$], got_q[$];
  int   bnd[16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097, 1048574,
                    1048575, 1048576, -1048576, -1048578, 32'h1000, 32'h1001};

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready)
      got_q.push_back('{bus.out_instr, bus.out_err, cyc, 3'd0, 32'd0});

  function automatic res_t ref_encode(input req_t r);
    res_t x;
    int v;
    v = int'($signed(r.imm));
    x.t = 0; x.fmt = r.fmt; x.imm = r.imm; x.err = 2'd0; x.instr = NOP;
    if (r.fmt > 3'd5) x.err = 2'd3;
    else if ((r.fmt == 3'd1 || r.fmt == 3'd2) && (v < -2048 || v > 2047)) x.err = 2'd1;
    else if (r.fmt == 3'd3 && (v < -4096 || v > 4094)) x.err = 2'd1;
    else if (r.fmt == 3'd5 && (v < -1048576 || v > 1048574)) x.err = 2'd1;
    else if ((r.fmt == 3'd3 || r.fmt == 3'd5) && (v % 2 != 0)) x.err = 2'd2;
    else if (r.fmt == 3'd4 && (v % 4096 != 0)) x.err = 2'd2;
    case (r.fmt)
      3'd0: x.instr = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
      3'd1: x.instr = {r.imm[11:0], r.rs1, r.f3, r.rd, r.op};
      3'd2: x.instr = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], r.op};
      3'd3: x.instr = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], r.op};
      3'd4: x.instr = {r.imm[31:12], r.rd, r.op};
      3'd5: x.instr = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.op};
      default: x.instr = NOP;
    endcase
    if (x.err != 2'd0) x.instr = NOP;
    return x;
  endfunction

  // Immediate generator, as a decoder would apply it to the emitted word.
  function automatic logic [31:0] imm_dec(input logic [2:0] fmt, input logic [31:0] w);
    case (fmt)
      3'd1:    imm_dec = {{20{w[31]}}, w[31:20]};
      3'd2:    imm_dec = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3:    imm_dec = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    imm_dec = {w[31:12], 12'd0};
      3'd5:    imm_dec = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm_dec = 32'd0;
    endcase
  endfunction

  function automatic req_t mk(input logic [2:0] fmt, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.imm = imm;
    r.op = 7'($urandom); r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
    r.f3 = 3'($urandom); r.f7 = 7'($urandom);
    return r;
  endfunction

  task automatic send(input req_t r, input bit rnd, output int acc);
    bit   got;
    res_t x;
    got = 1'b0; acc = -1;
    bus.in_fmt = r.fmt; bus.in_opcode = r.op; bus.in_rd = r.rd; bus.in_rs1 = r.rs1;
    bus.in_rs2 = r.rs2; bus.in_funct3 = r.f3; bus.in_funct7 = r.f7; bus.in_imm = r.imm;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk); #1;
      if (rnd && !got) bus.out_ready = 1'($urandom);
    end
    bus.in_valid = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, wanted 1 within 500 cycles");
    end else begin
      acc = cyc;
      x = ref_encode(r);
      exp_q.push_back(x);
      if (x.err == 2'd0) m_ok = (m_ok < CMAX) ? m_ok + 1 : CMAX;
      else               m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
    end
  endtask

  task automatic drain();
    bit to;
    to = 1'b1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (got_q.size() - gb >= exp_q.size()) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
    if (to) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d items, want %0d", got_q.size() - gb, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 || bus.out_err !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b instr=%h err=%0d, want 0/0/0", bus.out_valid, bus.out_instr, bus.out_err);
    end
    n_tests++;
    if (bus.cnt_ok !== 8'd0 || bus.cnt_err !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: ok=%0d err=%0d, want 0/0", bus.cnt_ok, bus.cnt_err);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int acc;
    req_t r;
    r = '{3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF};
    send(r, 1'b0, acc);
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: out_valid=%b one cycle after accept, want 0", bus.out_valid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF1_0093 || bus.out_err !== 2'd0) begin
      n_fail++;
      $display("FAIL latency_I: valid=%b instr=%h err=%0d, want 1/fff10093/0", bus.out_valid, bus.out_instr, bus.out_err);
    end
    @(posedge clk); #1;
    send('{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8}, 1'b0, acc);
    send('{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC}, 1'b0, acc);
    drain();
    if (got_q.size() - gb >= 3) begin
      n_tests++;
      if (got_q[gb+1].instr !== 32'h0020_8463) begin
        n_fail++; $display("FAIL enc_B: got %h want 00208463", got_q[gb+1].instr);
      end
      n_tests++;
      if (got_q[gb+2].instr !== 32'hFFDF_F06F) begin
        n_fail++; $display("FAIL enc_J: got %h want ffdff06f", got_q[gb+2].instr);
      end
    end
    ck = exp_q.size();
    n_tests++;
    if (bus.cnt_ok !== 8'd3) begin
      n_fail++; $display("FAIL cnt_ok_directed: got %0d want 3", bus.cnt_ok);
    end
  endtask

  task automatic test_errors();
    int acc;
    logic [1:0] want[3];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3;
    send(mk(3'd1, 32'd2048), 1'b0, acc);
    send(mk(3'd3, 32'd5), 1'b0, acc);
    send(mk(3'd6, $urandom), 1'b0, acc);
    drain();
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() - gb > ck + i) begin
        n_tests++;
        if (got_q[gb+ck+i].instr !== NOP || got_q[gb+ck+i].err !== want[i]) begin
          n_fail++;
          $display("FAIL err_case%0d: got %h/%0d want 00000013/%0d", i, got_q[gb+ck+i].instr, got_q[gb+ck+i].err, want[i]);
        end
      end
    end
    ck = exp_q.size();
    n_tests++;
    if (bus.cnt_err !== 8'd3 || bus.cnt_ok !== 8'd3) begin
      n_fail++; $display("FAIL cnt_errors: ok=%0d err=%0d want 3/3", bus.cnt_ok, bus.cnt_err);
    end
  endtask

  task automatic test_backpressure();
    int acc, base;
    logic [31:0] hi;
    logic [1:0]  he;
    req_t c;
    bus.out_ready = 1'b0;
    base = ck;
    send(mk(3'd1, 32'($urandom_range(0, 4095)) - 32'd2048), 1'b0, acc);
    send(mk(3'd0, $urandom), 1'b0, acc);
    c = mk(3'd4, $urandom & 32'hFFFF_F000);
    bus.in_fmt = c.fmt; bus.in_imm = c.imm; bus.in_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_full: in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid);
    end
    hi = bus.out_instr; he = bus.out_err;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (bus.out_instr !== hi || bus.out_err !== he || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stable: instr=%h err=%0d valid=%b rdy=%b want %h/%0d/1/0", bus.out_instr, bus.out_err, bus.out_valid, bus.in_ready, hi, he);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(c, 1'b0, acc);
    drain();
    for (int i = ck; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[gb+i].instr !== exp_q[i].instr || got_q[gb+i].err !== exp_q[i].err) begin
        n_fail++;
        $display("FAIL bp_item%0d: got %h/%0d want %h/%0d", i, got_q[gb+i].instr, got_q[gb+i].err, exp_q[i].instr, exp_q[i].err);
      end
    end
    if (got_q.size() - gb >= base + 3) begin
      n_tests++;
      if (got_q[gb+base+1].t - got_q[gb+base].t != 1 || got_q[gb+base+2].t - got_q[gb+base+1].t != 1) begin
        n_fail++;
        $display("FAIL bp_b2b: emit cycles %0d %0d %0d, want consecutive", got_q[gb+base].t, got_q[gb+base+1].t, got_q[gb+base+2].t);
      end
    end
    ck = exp_q.size();
    n_tests++;
    if (bus.cnt_ok !== 8'(m_ok) || bus.cnt_err !== 8'(m_err)) begin
      n_fail++; $display("FAIL bp_cnt: ok=%0d err=%0d want %0d/%0d", bus.cnt_ok, bus.cnt_err, m_ok, m_err);
    end
  endtask

  task automatic test_reset_midstream();
    int acc;
    bus.out_ready = 1'b0;
    send(mk(3'd2, 32'd100), 1'b0, acc);
    send(mk(3'd1, 32'd7), 1'b0, acc);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.cnt_ok !== 8'd0 || bus.cnt_err !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid: valid=%b ok=%0d err=%0d want 0/0/0", bus.out_valid, bus.cnt_ok, bus.cnt_err);
    end
    exp_q.delete(); ck = 0; gb = got_q.size(); m_ok = 0; m_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.out_ready = 1'b1;
    send(mk(3'd1, 32'hFFFF_F800), 1'b0, acc);
    drain();
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (got_q.size() - gb != 1) begin
      n_fail++; $display("FAIL rst_mid_count: got %0d items want 1", got_q.size() - gb);
    end else begin
      n_tests++;
      if (got_q[gb].instr !== exp_q[0].instr || got_q[gb].err !== exp_q[0].err) begin
        n_fail++;
        $display("FAIL rst_mid_item: got %h/%0d want %h/%0d", got_q[gb].instr, got_q[gb].err, exp_q[0].instr, exp_q[0].err);
      end
    end
    ck = exp_q.size();
    n_tests++;
    if (bus.cnt_ok !== 8'd1) begin
      n_fail++; $display("FAIL rst_mid_cnt: ok=%0d want 1", bus.cnt_ok);
    end
  endtask

  task automatic test_roundtrip();
    int acc;
    logic [2:0]  fmt;
    logic [31:0] imm;
    for (int k = 0; k < 1000; k++) begin
      fmt = 3'($urandom_range(0, 5));
      case (fmt)
        3'd1, 3'd2: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        3'd3:       imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
        3'd4:       imm = $urandom & 32'hFFFF_F000;
        3'd5:       imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
        default:    imm = $urandom;
      endcase
      if (k < 24) begin
        case (fmt)
          3'd1, 3'd2: imm = k[0] ? 32'd2047 : 32'hFFFF_F800;
          3'd3:       imm = k[0] ? 32'd4094 : 32'hFFFF_F000;
          3'd4:       imm = k[0] ? 32'hFFFF_F000 : 32'd0;
          3'd5:       imm = k[0] ? 32'd1048574 : 32'hFFF0_0000;
          default:    imm = imm;
        endcase
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        bus.out_ready = 1'($urandom);
      end
      bus.out_ready = 1'($urandom);
      send(mk(fmt, imm), 1'b1, acc);
    end
    drain();
    for (int i = ck; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[gb+i].instr !== exp_q[i].instr || got_q[gb+i].err !== exp_q[i].err) begin
        n_fail++;
        $display("FAIL rt_item%0d: got %h/%0d want %h/%0d", i, got_q[gb+i].instr, got_q[gb+i].err, exp_q[i].instr, exp_q[i].err);
      end
      if (exp_q[i].fmt != 3'd0) begin
        n_tests++;
        if (imm_dec(exp_q[i].fmt, got_q[gb+i].instr) !== exp_q[i].imm) begin
          n_fail++;
          $display("FAIL rt_imm%0d: fmt %0d decoded %h want %h", i, exp_q[i].fmt, imm_dec(exp_q[i].fmt, got_q[gb+i].instr), exp_q[i].imm);
        end
      end
    end
    ck = exp_q.size();
    n_tests++;
    if (bus.cnt_ok !== 8'(CMAX) || bus.cnt_err !== 8'(m_err)) begin
      n_fail++; $display("FAIL rt_cnt_sat: ok=%0d err=%0d want %0d/%0d", bus.cnt_ok, bus.cnt_err, CMAX, m_err);
    end
  endtask

  task automatic test_mixed();
    int acc;
    logic [2:0]  fmt;
    logic [31:0] imm;
    for (int k = 0; k < 300; k++) begin
      fmt = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:       imm = 32'(bnd[$urandom_range(0, 15)]);
        default: imm = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 1));
      endcase
      bus.out_ready = 1'($urandom);
      send(mk(fmt, imm), 1'b1, acc);
    end
    drain();
    for (int i = ck; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[gb+i].instr !== exp_q[i].instr || got_q[gb+i].err !== exp_q[i].err) begin
        n_fail++;
        $display("FAIL mix_item%0d: fmt %0d imm %h got %h/%0d want %h/%0d", i, exp_q[i].fmt, exp_q[i].imm, got_q[gb+i].instr, got_q[gb+i].err, exp_q[i].instr, exp_q[i].err);
      end
    end
    ck = exp_q.size();
    n_tests++;
    if (bus.cnt_ok !== 8'(m_ok) || bus.cnt_err !== 8'(m_err)) begin
      n_fail++; $display("FAIL mix_cnt: ok=%0d err=%0d want %0d/%0d", bus.cnt_ok, bus.cnt_err, m_ok, m_err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_fmt = '0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_midstream();
    test_roundtrip();
    test_mixed();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
